// File: rtl/sequence_matcher_pkg.sv
// Shared types and sizing helpers for the memory-game sequence matcher.
package game_pkg;

    localparam int DIGIT_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CAPTURE    = 3'd1,
        ST_SHOW_ON    = 3'd2,
        ST_SHOW_GAP   = 3'd3,
        ST_WAIT_INPUT = 3'd4,
        ST_PASS       = 3'd5,
        ST_FAIL       = 3'd6
    } state_t;

    // Index width for a sequence of max_len digits; never below one bit.
    function automatic int idx_width(input int max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

    // Width of a counter that must reach n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sequence_matcher_digit_store.sv
// Digit memory: one synchronous write port, two combinational read ports.
module digit_store
    import game_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [DIGIT_W-1:0] wr_data,
    input  logic [IDX_W-1:0]   rd_a_idx,
    output logic [DIGIT_W-1:0] rd_a_data,
    input  logic [IDX_W-1:0]   rd_b_idx,
    output logic [DIGIT_W-1:0] rd_b_data
);

    // Contents survive reset on purpose; each game overwrites as it grows.
    logic [DIGIT_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_a_data = mem_q[rd_a_idx];
    assign rd_b_data = mem_q[rd_b_idx];

endmodule

// File: rtl/sequence_matcher.sv
// Memory-game round controller: grows a digit sequence, replays it, then checks the player's keys.
module sequence_matcher
    import game_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int SHOW_CYCLES = 25_000_000,
    parameter int TIMEOUT     = 250_000_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [DIGIT_W-1:0]             rand_num,
    input  logic                           key_valid,
    input  logic [DIGIT_W-1:0]             key_digit,
    output logic                           show_valid,
    output logic [DIGIT_W-1:0]             show_digit,
    output logic [$clog2(MAX_LEN+1)-1:0]   level,
    output logic                           busy,
    output logic                           pass,
    output logic                           fail,
    output logic                           win
);

    localparam int LVL_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = idx_width(MAX_LEN);
    localparam int SHW_W = cnt_width(SHOW_CYCLES);
    localparam int TMO_W = cnt_width(TIMEOUT);

    localparam logic [SHW_W-1:0] SHOW_LAST = SHW_W'(SHOW_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(MAX_LEN);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);

    state_t             state_q, state_d;
    logic [LVL_W-1:0]   len_q, len_d;
    logic [IDX_W-1:0]   show_idx_q, show_idx_d;
    logic [IDX_W-1:0]   in_idx_q, in_idx_d;
    logic [SHW_W-1:0]   show_cnt_q, show_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

    logic               show_valid_q, show_valid_d;
    logic [DIGIT_W-1:0] show_digit_q, show_digit_d;
    logic               busy_q, busy_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               win_q, win_d;

    logic               wr_en;
    logic [LVL_W-1:0]   len_m1;
    logic [IDX_W-1:0]   wr_idx;
    logic [DIGIT_W-1:0] show_rd_data;
    logic [DIGIT_W-1:0] in_rd_data;
    logic               last_show;
    logic               last_in;

    assign len_m1    = len_q - LVL_ONE;
    assign wr_idx    = len_m1[IDX_W-1:0];
    assign last_show = (show_idx_q == wr_idx);
    assign last_in   = (in_idx_q == wr_idx);

    // Show port reads the upcoming index so the registered digit lines up with show_valid.
    digit_store #(
        .DEPTH (MAX_LEN),
        .IDX_W (IDX_W)
    ) u_store (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (rand_num),
        .rd_a_idx  (show_idx_d),
        .rd_a_data (show_rd_data),
        .rd_b_idx  (in_idx_q),
        .rd_b_data (in_rd_data)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        show_idx_d = show_idx_q;
        in_idx_d   = in_idx_q;
        show_cnt_d = show_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        wr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = LVL_ONE;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                wr_en      = 1'b1;
                show_idx_d = '0;
                show_cnt_d = '0;
                state_d    = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (show_cnt_q >= SHOW_LAST) begin
                    show_cnt_d = '0;
                    state_d    = ST_SHOW_GAP;
                end else begin
                    show_cnt_d = show_cnt_q + 1'b1;
                end
            end
            ST_SHOW_GAP: begin
                if (last_show) begin
                    in_idx_d  = '0;
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT_INPUT;
                end else begin
                    show_idx_d = show_idx_q + 1'b1;
                    state_d    = ST_SHOW_ON;
                end
            end
            ST_WAIT_INPUT: begin
                // A key in the final timeout cycle takes priority over the timeout.
                if (key_valid) begin
                    if (key_digit != in_rd_data) begin
                        state_d = ST_FAIL;
                    end else if (last_in) begin
                        state_d = ST_PASS;
                    end else begin
                        in_idx_d  = in_idx_q + 1'b1;
                        tmo_cnt_d = '0;
                    end
                end else if (tmo_cnt_q >= TMO_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_PASS: begin
                if (len_q == LVL_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    len_d   = len_q + LVL_ONE;
                    state_d = ST_CAPTURE;
                end
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        show_valid_d = (state_d == ST_SHOW_ON);
        show_digit_d = '0;
        if (show_valid_d) begin
            // Bypass the digit being written this cycle (first replay of a new round).
            show_digit_d = (wr_en && (wr_idx == show_idx_d)) ? rand_num : show_rd_data;
        end
        busy_d = (state_d != ST_IDLE);
        pass_d = (state_d == ST_PASS);
        win_d  = pass_d && (len_q == LVL_MAX);
        fail_d = (state_d == ST_FAIL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            show_idx_q   <= '0;
            in_idx_q     <= '0;
            show_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            show_valid_q <= 1'b0;
            show_digit_q <= '0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            show_idx_q   <= show_idx_d;
            in_idx_q     <= in_idx_d;
            show_cnt_q   <= show_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            show_valid_q <= show_valid_d;
            show_digit_q <= show_digit_d;
            busy_q       <= busy_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            win_q        <= win_d;
        end
    end

    assign show_valid = show_valid_q;
    assign show_digit = show_digit_q;
    assign level      = len_q;
    assign busy       = busy_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign win        = win_q;

endmodule

// File: tb/tb_sequence_matcher.sv
// Directed bench for sequence_matcher with MAX_LEN=4, SHOW_CYCLES=4, TIMEOUT=20.
module tb_sequence_matcher;

    localparam int MAX_LEN = 4;
    localparam int SHOW    = 4;
    localparam int TMO     = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] rand_num = 2'd0;
    logic       key_valid = 1'b0;
    logic [1:0] key_digit = 2'd0;
    logic       show_valid;
    logic [1:0] show_digit;
    logic [2:0] level;
    logic       busy;
    logic       pass;
    logic       fail;
    logic       win;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sequence_matcher #(
        .MAX_LEN     (MAX_LEN),
        .SHOW_CYCLES (SHOW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rand_num   (rand_num),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .show_valid (show_valid),
        .show_digit (show_digit),
        .level      (level),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .win        (win)
    );

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [1:0] d);
        key_valid = 1'b1;
        key_digit = d;
        cyc();
        key_valid = 1'b0;
    endtask

    // Leaves the DUT in its CAPTURE cycle with rand_num = r.
    task automatic begin_game(input logic [1:0] r);
        start    = 1'b1;
        rand_num = r;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        cyc(2);
        checks++; if ({show_valid, show_digit} !== 3'b000) $display("FAIL reset_show: got %b expected 000", {show_valid, show_digit}); else passed++;
        checks++; if ({busy, pass, fail, win} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {busy, pass, fail, win}); else passed++;
        checks++; if (level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", level); else passed++;
        reset = 1'b1;
        cyc();
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_first_round;
        begin_game(2'd2);
        checks++; if ({busy, show_valid} !== 2'b10) $display("FAIL capture_busy_show: got %b expected 10", {busy, show_valid}); else passed++;
        checks++; if (level !== 3'd1) $display("FAIL capture_level: got %0d expected 1", level); else passed++;
        cyc();
        rand_num = 2'd3;
        for (int i = 0; i < SHOW; i++) begin
            checks++; if ({show_valid, show_digit} !== 3'b110) $display("FAIL r1_show%0d: got %b expected 110", i, {show_valid, show_digit}); else passed++;
            cyc();
        end
        checks++; if (show_valid !== 1'b0) $display("FAIL r1_gap: got %b expected 0", show_valid); else passed++;
        cyc();
        checks++; if ({show_valid, busy, pass} !== 3'b010) $display("FAIL r1_wait: got %b expected 010", {show_valid, busy, pass}); else passed++;
        press(2'd2);
        checks++; if ({pass, win, fail} !== 3'b100) $display("FAIL r1_pass: got %b expected 100", {pass, win, fail}); else passed++;
        rand_num = 2'd1;
        cyc();
        checks++; if ({pass, level} !== 4'b0010) $display("FAIL r2_capture: got %b expected 0010", {pass, level}); else passed++;
        cyc();
        rand_num = 2'd3;
        $display("test_first_round done");
    endtask

    task automatic test_second_round;
        logic [1:0] exp_seq [2];
        exp_seq[0] = 2'd2;
        exp_seq[1] = 2'd1;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < SHOW; i++) begin
                checks++; if ({show_valid, show_digit} !== {1'b1, exp_seq[j]}) $display("FAIL r2_show%0d_%0d: got %b expected %b", j, i, {show_valid, show_digit}, {1'b1, exp_seq[j]}); else passed++;
                cyc();
            end
            checks++; if (show_valid !== 1'b0) $display("FAIL r2_gap%0d: got %b expected 0", j, show_valid); else passed++;
            cyc();
        end
        $display("test_second_round done");
    endtask

    task automatic test_wrong_key;
        press(2'd2);
        checks++; if ({pass, fail} !== 2'b00) $display("FAIL wk_first: got %b expected 00", {pass, fail}); else passed++;
        press(2'd3);
        checks++; if ({fail, pass, busy} !== 3'b101) $display("FAIL wk_fail: got %b expected 101", {fail, pass, busy}); else passed++;
        cyc();
        checks++; if ({busy, fail} !== 2'b00) $display("FAIL wk_idle: got %b expected 00", {busy, fail}); else passed++;
        checks++; if (level !== 3'd2) $display("FAIL wk_level: got %0d expected 2", level); else passed++;
        $display("test_wrong_key done");
    endtask

    task automatic test_timeout;
        begin_game(2'd0);
        cyc(1 + SHOW + 1);
        cyc(TMO - 1);
        checks++; if ({fail, busy} !== 2'b01) $display("FAIL to_before: got %b expected 01", {fail, busy}); else passed++;
        cyc();
        checks++; if (fail !== 1'b1) $display("FAIL to_fail: got %b expected 1", fail); else passed++;
        cyc();
        checks++; if (busy !== 1'b0) $display("FAIL to_idle: got %b expected 0", busy); else passed++;
        // Key on the last allowed cycle must be accepted.
        begin_game(2'd1);
        cyc(1 + SHOW + 1);
        cyc(TMO - 1);
        press(2'd1);
        checks++; if ({pass, fail} !== 2'b10) $display("FAIL to_late_key: got %b expected 10", {pass, fail}); else passed++;
        rand_num = 2'd0;
        cyc();
        checks++; if ({fail, level} !== 4'b0010) $display("FAIL to_next_round: got %b expected 0010", {fail, level}); else passed++;
        cyc(1 + 2 * (SHOW + 1));
        press(2'd2);
        cyc(2);
        checks++; if (busy !== 1'b0) $display("FAIL to_abandon: got %b expected 0", busy); else passed++;
        $display("test_timeout done");
    endtask

    task automatic test_win;
        logic [1:0] seq [4];
        seq[0] = 2'd3;
        seq[1] = 2'd0;
        seq[2] = 2'd1;
        seq[3] = 2'd2;
        for (int r = 1; r <= MAX_LEN; r++) begin
            if (r == 1) begin
                begin_game(seq[0]);
            end else begin
                rand_num = seq[r-1];
                cyc();
            end
            cyc();
            cyc(r * (SHOW + 1));
            checks++; if (level !== 3'(r)) $display("FAIL win_level%0d: got %0d expected %0d", r, level, r); else passed++;
            for (int k = 0; k < r; k++) begin
                press(seq[k]);
            end
            checks++; if ({pass, win, fail} !== {1'b1, (r == MAX_LEN), 1'b0}) $display("FAIL win_round%0d: got %b expected %b", r, {pass, win, fail}, {1'b1, (r == MAX_LEN), 1'b0}); else passed++;
        end
        cyc();
        checks++; if ({busy, pass, win} !== 3'b000) $display("FAIL win_idle: got %b expected 000", {busy, pass, win}); else passed++;
        checks++; if (level !== 3'd4) $display("FAIL win_level_hold: got %0d expected 4", level); else passed++;
        $display("test_win done");
    endtask

    task automatic test_ignored;
        begin_game(2'd2);
        cyc();
        press(2'd1);
        checks++; if ({fail, show_valid, show_digit} !== 4'b0110) $display("FAIL ign_key: got %b expected 0110", {fail, show_valid, show_digit}); else passed++;
        cyc(SHOW);
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++; if ({busy, fail, level} !== 5'b10001) $display("FAIL ign_start: got %b expected 10001", {busy, fail, level}); else passed++;
        press(2'd2);
        checks++; if (pass !== 1'b1) $display("FAIL ign_pass: got %b expected 1", pass); else passed++;
        rand_num = 2'd1;
        cyc();
        checks++; if (level !== 3'd2) $display("FAIL ign_level: got %0d expected 2", level); else passed++;
        cyc();
        $display("test_ignored done");
    endtask

    task automatic test_reset_mid;
        checks++; if (show_valid !== 1'b1) $display("FAIL rm_pre: got %b expected 1", show_valid); else passed++;
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({show_valid, show_digit, busy} !== 4'b0000) $display("FAIL rm_async: got %b expected 0000", {show_valid, show_digit, busy}); else passed++;
        checks++; if (level !== 3'd0) $display("FAIL rm_level: got %0d expected 0", level); else passed++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(2);
        checks++; if ({busy, show_valid} !== 2'b00) $display("FAIL rm_idle: got %b expected 00", {busy, show_valid}); else passed++;
        begin_game(2'd3);
        checks++; if ({busy, level} !== 4'b1001) $display("FAIL rm_restart: got %b expected 1001", {busy, level}); else passed++;
        $display("test_reset_mid done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_round();
        test_second_round();
        test_wrong_key();
        test_timeout();
        test_win();
        test_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
